prog_loader_ctrl: RTL and testbench
===================================

PROG_LOADER_CTRL -- requirements
Module: prog_loader_ctrl

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 64, maximum instruction words accepted per load.
REQ-002 SHALL have parameter BYTE_TIMEOUT, default 255, idle cycles allowed between bytes of a partial word.
REQ-003 SHALL have ports:
- CLK  in  1  sole clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  level; begins a load from IDLE, resumes from HALT.
- CLR  in  1  synchronous return to IDLE from any state.
- HALT  in  1  RUN -> HALT request.
- STEP  in  1  single-step request, level; rising edge detected internally.
- BYTE_IN  in  8  program byte.
- BYTE_VLD  in  1  BYTE_IN valid.
- BYTE_RDY  out  1  controller accepts a byte.
- CPU_RSTN  out  1  datapath reset, active-low.
- CPU_CE  out  1  datapath clock enable.
- CPU_WE  out  1  instruction-memory write strobe.
- CPU_WINS  out  32  instruction word to write.
- WCOUNT  out  $clog2(MAX_WORDS)+1  words written in the current load.
- CYC_CNT  out  32  datapath cycles executed since the load.
- STATE  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3.
- ERR  out  1  sticky load error.

Function
REQ-004 SHALL accept a byte only on a cycle with BYTE_VLD=1 and BYTE_RDY=1; BYTE_RDY SHALL be 1 only in LOAD.
REQ-005 SHALL pack bytes big-endian: first byte -> CPU_WINS[31:24], fourth -> [7:0].
REQ-006 On the cycle after the fourth byte is accepted, SHALL assert CPU_WE and CPU_CE for exactly one cycle with CPU_WINS stable, and SHALL increment WCOUNT in that same cycle.
REQ-007 SHALL NOT write the terminator word 0xFFFFFFFF; it SHALL cause LOAD -> RUN.
REQ-008 SHALL perform LOAD -> RUN after the write that makes WCOUNT equal MAX_WORDS; later bytes are not accepted.
REQ-009 In LOAD, if 1-3 bytes of a word are held and no byte is accepted for BYTE_TIMEOUT consecutive cycles, SHALL set ERR, discard the partial word and go to IDLE.
REQ-010 IDLE: CPU_RSTN=0, CPU_CE=0, CPU_WE=0; START -> LOAD, clearing byte index, WCOUNT, CYC_CNT and ERR.
REQ-011 On every entry to RUN from LOAD, SHALL drive CPU_RSTN=0 for exactly one cycle (CPU_CE=0) to rewind the PC, then CPU_RSTN=1.
REQ-012 RUN: CPU_CE=1 every cycle after the rewind cycle; CYC_CNT increments per CE cycle and saturates at 0xFFFFFFFF; HALT=1 -> HALT, with CE deasserted from the next cycle.
REQ-013 HALT: CPU_CE=0, CYC_CNT holds; START -> RUN without rewind; START is ignored in LOAD and RUN.
REQ-014 Priority when inputs coincide: CLR > HALT > START > STEP.
REQ-015 CLR SHALL drop any partial word, leave ERR unchanged and enter IDLE in the next cycle.

Reset
REQ-016 RST low SHALL immediately force STATE=IDLE, BYTE_RDY=0, CPU_RSTN=0, CPU_CE=0, CPU_WE=0, CPU_WINS=0, WCOUNT=0, CYC_CNT=0, ERR=0 and clear the STEP edge detector, including mid-load or mid-run.
REQ-017 Deassertion of RST SHALL take effect on the next rising CLK edge; no input is sampled before that edge.

Configuration
REQ-018 Macro PROG_LOADER_STEP_EN defined: a STEP rising edge in HALT SHALL assert CPU_CE for exactly one cycle and increment CYC_CNT by one.
REQ-019 Macro PROG_LOADER_STEP_EN undefined: STEP port SHALL remain present but be ignored; CPU_CE SHALL stay 0 in HALT.

Structure
REQ-020 Package mips_ctrl_pkg SHALL hold the state enum (IDLE/LOAD/RUN/HALT) and constant TERM_WORD=32'hFFFFFFFF.
REQ-021 Byte assembly and byte-index counting SHALL live in sub-module byte_packer; FSM, counters and timeout stay in prog_loader_ctrl.

Verification
REQ-022 Bench SHALL cover:
- START, bytes 20 08 00 05 then FF FF FF FF -> one CPU_WE with CPU_WINS=0x20080005, WCOUNT=1, one-cycle CPU_RSTN low, STATE=2.
- MAX_WORDS=2, stream three words -> two writes, RUN after second write, BYTE_RDY=0 afterwards.
- Two bytes then 255 idle cycles -> ERR=1, STATE=0, no CPU_WE.
- RUN 10 cycles, HALT, with PROG_LOADER_STEP_EN three STEP pulses -> CYC_CNT=13, three single-cycle CE pulses; without macro CYC_CNT=10.
- CLR and HALT asserted together in RUN -> STATE=0 next cycle, CPU_RSTN=0.
- RST low mid-load after 3 bytes -> all outputs at reset values immediately; new START and 4 bytes write the full new word.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the program loader controller.
// State encoding matches the STATE output: IDLE=0, LOAD=1, RUN=2, HALT=3.
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [31:0] TERM_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] CYC_MAX   = 32'hFFFF_FFFF;

endpackage

// File: rtl/byte_packer.sv
// Assembles four accepted bytes into a big-endian instruction word.
// The fourth byte is not stored; it is forwarded straight into word_asm.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_asm,
  output logic        word_done,
  output logic        partial
);

  logic [1:0] idx_reg;
  logic [1:0] idx_next;
  logic [7:0] lane_reg [3];

  always_comb begin
    idx_next = idx_reg;
    if (clr) begin
      idx_next = 2'd0;
    end else if (accept) begin
      idx_next = idx_reg + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= 2'd0;
    end else begin
      idx_reg <= idx_next;
    end
  end

  // Lane 0 is the first byte of a word and lands in bits [31:24].
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg[gi] <= 8'd0;
        end else if (accept && !clr && (idx_reg == 2'(gi))) begin
          lane_reg[gi] <= byte_in;
        end
      end
    end
  endgenerate

  assign word_asm  = {lane_reg[0], lane_reg[1], lane_reg[2], byte_in};
  assign word_done = accept && !clr && (idx_reg == 2'd3);
  assign partial   = (idx_reg != 2'd0);

endmodule

// File: rtl/prog_loader_ctrl.sv
// Loads a byte stream into instruction memory, then runs/halts/steps the datapath.
// Define PROG_LOADER_STEP_EN to enable single-step clock enables while halted.
module prog_loader_ctrl #(
  parameter int MAX_WORDS    = 64,
  parameter int BYTE_TIMEOUT = 255
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic                         CLR,
  input  logic                         HALT,
  input  logic                         STEP,
  input  logic [7:0]                   BYTE_IN,
  input  logic                         BYTE_VLD,
  output logic                         BYTE_RDY,
  output logic                         CPU_RSTN,
  output logic                         CPU_CE,
  output logic                         CPU_WE,
  output logic [31:0]                  CPU_WINS,
  output logic [$clog2(MAX_WORDS):0]   WCOUNT,
  output logic [31:0]                  CYC_CNT,
  output logic [1:0]                   STATE,
  output logic                         ERR
);

  import mips_ctrl_pkg::*;

  localparam int WCW = $clog2(MAX_WORDS) + 1;
  localparam int TOW = (BYTE_TIMEOUT < 2) ? 1 : $clog2(BYTE_TIMEOUT);

`ifdef PROG_LOADER_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  state_t          state_reg, state_next;
  logic            rewind_reg, rewind_next;
  logic            we_reg, we_next;
  logic [31:0]     wins_reg, wins_next;
  logic [WCW-1:0]  wcount_reg, wcount_next;
  logic [31:0]     cyc_cnt_reg, cyc_cnt_next;
  logic            err_reg, err_next;
  logic [TOW-1:0]  idle_cnt_reg, idle_cnt_next;
  logic            step_d_reg;
  logic            step_ce_reg, step_ce_next;

  logic            accept;
  logic            pk_clr;
  logic [31:0]     word_asm;
  logic            word_done;
  logic            partial;
  logic            run_ce;
  logic            step_rise;

  byte_packer u_packer (
    .clk       (CLK),
    .rst_n     (RST),
    .clr       (pk_clr),
    .accept    (accept),
    .byte_in   (BYTE_IN),
    .word_asm  (word_asm),
    .word_done (word_done),
    .partial   (partial)
  );

  // Once the final permitted word is written, stop taking bytes while the FSM leaves LOAD.
  assign BYTE_RDY  = (state_reg == mips_ctrl_pkg::LOAD) && (wcount_reg != WCW'(MAX_WORDS));
  assign accept    = BYTE_VLD && BYTE_RDY;
  assign run_ce    = (state_reg == mips_ctrl_pkg::RUN) && !rewind_reg;
  assign step_rise = STEP && !step_d_reg;

  assign CPU_RSTN  = (state_reg != mips_ctrl_pkg::IDLE) && !rewind_reg;
  assign CPU_CE    = we_reg || run_ce || step_ce_reg;
  assign CPU_WE    = we_reg;
  assign CPU_WINS  = wins_reg;
  assign WCOUNT    = wcount_reg;
  assign CYC_CNT   = cyc_cnt_reg;
  assign STATE     = state_reg;
  assign ERR       = err_reg;

  always_comb begin
    state_next    = state_reg;
    rewind_next   = 1'b0;
    we_next       = 1'b0;
    wins_next     = wins_reg;
    wcount_next   = wcount_reg;
    cyc_cnt_next  = cyc_cnt_reg;
    err_next      = err_reg;
    idle_cnt_next = idle_cnt_reg;
    step_ce_next  = 1'b0;
    pk_clr        = 1'b0;

    if ((run_ce || step_ce_reg) && (cyc_cnt_reg != CYC_MAX)) begin
      cyc_cnt_next = cyc_cnt_reg + 32'd1;
    end

    case (state_reg)
      mips_ctrl_pkg::IDLE: begin
        if (START) begin
          state_next    = mips_ctrl_pkg::LOAD;
          pk_clr        = 1'b1;
          wcount_next   = '0;
          cyc_cnt_next  = '0;
          err_next      = 1'b0;
          idle_cnt_next = '0;
        end
      end

      mips_ctrl_pkg::LOAD: begin
        if (we_reg && (wcount_reg == WCW'(MAX_WORDS))) begin
          state_next  = mips_ctrl_pkg::RUN;
          rewind_next = 1'b1;
        end else if (word_done) begin
          idle_cnt_next = '0;
          if (word_asm == TERM_WORD) begin
            state_next  = mips_ctrl_pkg::RUN;
            rewind_next = 1'b1;
          end else begin
            we_next     = 1'b1;
            wins_next   = word_asm;
            wcount_next = wcount_reg + WCW'(1);
          end
        end else if (accept || !partial) begin
          idle_cnt_next = '0;
        end else if (idle_cnt_reg == TOW'(BYTE_TIMEOUT - 1)) begin
          state_next    = mips_ctrl_pkg::IDLE;
          err_next      = 1'b1;
          pk_clr        = 1'b1;
          idle_cnt_next = '0;
        end else begin
          idle_cnt_next = idle_cnt_reg + TOW'(1);
        end
      end

      mips_ctrl_pkg::RUN: begin
        if (HALT) begin
          state_next = mips_ctrl_pkg::HALT;
        end
      end

      mips_ctrl_pkg::HALT: begin
        if (HALT) begin
          state_next = mips_ctrl_pkg::HALT;
        end else if (START) begin
          state_next = mips_ctrl_pkg::RUN;
        end else if (STEP_EN && step_rise) begin
          step_ce_next = 1'b1;
        end
      end

      default: state_next = mips_ctrl_pkg::IDLE;
    endcase

    // Clear overrides everything, including a word completing on the same edge.
    if (CLR) begin
      state_next    = mips_ctrl_pkg::IDLE;
      rewind_next   = 1'b0;
      we_next       = 1'b0;
      wins_next     = wins_reg;
      wcount_next   = wcount_reg;
      err_next      = err_reg;
      idle_cnt_next = '0;
      step_ce_next  = 1'b0;
      pk_clr        = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= mips_ctrl_pkg::IDLE;
      rewind_reg   <= 1'b0;
      we_reg       <= 1'b0;
      wins_reg     <= '0;
      wcount_reg   <= '0;
      cyc_cnt_reg  <= '0;
      err_reg      <= 1'b0;
      idle_cnt_reg <= '0;
      step_d_reg   <= 1'b0;
      step_ce_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rewind_reg   <= rewind_next;
      we_reg       <= we_next;
      wins_reg     <= wins_next;
      wcount_reg   <= wcount_next;
      cyc_cnt_reg  <= cyc_cnt_next;
      err_reg      <= err_next;
      idle_cnt_reg <= idle_cnt_next;
      step_d_reg   <= STEP;
      step_ce_reg  <= step_ce_next;
    end
  end

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Directed bench for prog_loader_ctrl (MAX_WORDS=2, BYTE_TIMEOUT=255).
// Step expectations follow whether PROG_LOADER_STEP_EN is defined.
module tb_prog_loader_ctrl;

`ifdef PROG_LOADER_STEP_EN
  localparam int STEP_CE = 1;
`else
  localparam int STEP_CE = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clr, halt, step;
  logic [7:0]  byte_in;
  logic        byte_vld;
  logic        byte_rdy;
  logic        cpu_rstn, cpu_ce, cpu_we;
  logic [31:0] cpu_wins;
  logic [1:0]  wcount;
  logic [31:0] cyc_cnt;
  logic [1:0]  state;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;
  int we_cnt       = 0;
  int ce_cnt       = 0;
  int rstn_low_cnt = 0;

  prog_loader_ctrl #(.MAX_WORDS(2), .BYTE_TIMEOUT(255)) dut (
    .CLK(clk), .RST(rst_n), .START(start), .CLR(clr), .HALT(halt), .STEP(step),
    .BYTE_IN(byte_in), .BYTE_VLD(byte_vld), .BYTE_RDY(byte_rdy),
    .CPU_RSTN(cpu_rstn), .CPU_CE(cpu_ce), .CPU_WE(cpu_we), .CPU_WINS(cpu_wins),
    .WCOUNT(wcount), .CYC_CNT(cyc_cnt), .STATE(state), .ERR(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cpu_we) we_cnt++;
    if (cpu_ce) ce_cnt++;
    if (!cpu_rstn) rstn_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit acc);
    byte_in  = b;
    byte_vld = 1'b1;
    acc      = byte_rdy;
    tick(1);
    byte_vld = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, output int n_acc);
    bit acc;
    n_acc = 0;
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8], acc);
      if (acc) n_acc++;
    end
  endtask

  task automatic reset_values(input string pfx);
    check({pfx, " state"},    32'(state),    32'd0);
    check({pfx, " byte_rdy"}, 32'(byte_rdy), 32'd0);
    check({pfx, " cpu_rstn"}, 32'(cpu_rstn), 32'd0);
    check({pfx, " cpu_ce"},   32'(cpu_ce),   32'd0);
    check({pfx, " cpu_we"},   32'(cpu_we),   32'd0);
    check({pfx, " cpu_wins"}, cpu_wins,      32'd0);
    check({pfx, " wcount"},   32'(wcount),   32'd0);
    check({pfx, " cyc_cnt"},  cyc_cnt,       32'd0);
    check({pfx, " err"},      32'(err),      32'd0);
  endtask

  initial begin
    int we0, ce0, rl0, n_acc;
    rst_n = 1'b0; start = 0; clr = 0; halt = 0; step = 0; byte_in = 8'h00; byte_vld = 0;
    #2;
    reset_values("por");
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Single word then terminator.
    start = 1; tick(1); start = 0;
    check("load state", 32'(state), 32'd1);
    check("load byte_rdy", 32'(byte_rdy), 32'd1);
    check("load cpu_rstn", 32'(cpu_rstn), 32'd1);
    we0 = we_cnt; rl0 = rstn_low_cnt;
    send_word(32'h2008_0005, n_acc);
    check("w1 cpu_we", 32'(cpu_we), 32'd1);
    check("w1 cpu_ce", 32'(cpu_ce), 32'd1);
    check("w1 cpu_wins", cpu_wins, 32'h2008_0005);
    check("w1 wcount", 32'(wcount), 32'd1);
    send_word(32'hFFFF_FFFF, n_acc);
    check("term state", 32'(state), 32'd2);
    check("term rewind rstn", 32'(cpu_rstn), 32'd0);
    check("term rewind ce", 32'(cpu_ce), 32'd0);
    check("term no we", 32'(cpu_we), 32'd0);
    tick(1);
    check("run rstn", 32'(cpu_rstn), 32'd1);
    check("run ce", 32'(cpu_ce), 32'd1);
    check("term we count", 32'(we_cnt - we0), 32'd1);
    check("term rstn low count", 32'(rstn_low_cnt - rl0), 32'd1);
    check("term wins held", cpu_wins, 32'h2008_0005);
    check("term wcount", 32'(wcount), 32'd1);

    // Ten CE cycles, halt, then three step pulses.
    tick(9);
    check("run cyc 9", cyc_cnt, 32'd9);
    halt = 1; tick(1); halt = 0;
    check("halt state", 32'(state), 32'd3);
    check("halt cyc", cyc_cnt, 32'd10);
    check("halt ce", 32'(cpu_ce), 32'd0);
    tick(2);
    check("halt cyc hold", cyc_cnt, 32'd10);
    ce0 = ce_cnt;
    for (int i = 0; i < 3; i++) begin
      step = 1; tick(1);
      check($sformatf("step%0d ce", i), 32'(cpu_ce), 32'(STEP_CE));
      step = 0; tick(1);
      check($sformatf("step%0d ce off", i), 32'(cpu_ce), 32'd0);
      tick(1);
    end
    check("step cyc", cyc_cnt, 32'(10 + 3 * STEP_CE));
    check("step ce count", 32'(ce_cnt - ce0), 32'(3 * STEP_CE));
    start = 1; tick(1); start = 0;
    check("resume state", 32'(state), 32'd2);
    check("resume no rewind", 32'(cpu_rstn), 32'd1);
    check("resume ce", 32'(cpu_ce), 32'd1);

    // CLR beats HALT.
    clr = 1; halt = 1; tick(1); clr = 0; halt = 0;
    check("clr state", 32'(state), 32'd0);
    check("clr cpu_rstn", 32'(cpu_rstn), 32'd0);
    check("clr cpu_ce", 32'(cpu_ce), 32'd0);

    // MAX_WORDS=2 limit.
    start = 1; tick(1); start = 0;
    we0 = we_cnt; rl0 = rstn_low_cnt;
    send_word(32'h1122_3344, n_acc);
    check("max w1 wins", cpu_wins, 32'h1122_3344);
    send_word(32'h5566_7788, n_acc);
    check("max w2 we", 32'(cpu_we), 32'd1);
    check("max w2 wcount", 32'(wcount), 32'd2);
    check("max w2 byte_rdy", 32'(byte_rdy), 32'd0);
    send_word(32'h99AA_BBCC, n_acc);
    check("max w3 accepted", 32'(n_acc), 32'd0);
    check("max state", 32'(state), 32'd2);
    check("max byte_rdy", 32'(byte_rdy), 32'd0);
    check("max we count", 32'(we_cnt - we0), 32'd2);
    check("max wins", cpu_wins, 32'h5566_7788);
    check("max rstn low count", 32'(rstn_low_cnt - rl0), 32'd1);
    clr = 1; tick(1); clr = 0;

    // Partial-word timeout.
    start = 1; tick(1); start = 0;
    we0 = we_cnt;
    begin
      bit acc;
      send_byte(8'hAA, acc);
      send_byte(8'hBB, acc);
    end
    tick(254);
    check("to 254 state", 32'(state), 32'd1);
    check("to 254 err", 32'(err), 32'd0);
    tick(1);
    check("to 255 state", 32'(state), 32'd0);
    check("to 255 err", 32'(err), 32'd1);
    check("to no we", 32'(we_cnt - we0), 32'd0);
    start = 1; tick(1); start = 0;
    check("restart err", 32'(err), 32'd0);
    check("restart wcount", 32'(wcount), 32'd0);

    // Asynchronous reset after three bytes.
    begin
      bit acc;
      send_byte(8'h01, acc);
      send_byte(8'h02, acc);
      send_byte(8'h03, acc);
    end
    #2 rst_n = 1'b0;
    #1;
    reset_values("midload rst");
    tick(1);
    rst_n = 1'b1;
    tick(1);
    start = 1; tick(1); start = 0;
    send_word(32'hDEAD_BEEF, n_acc);
    check("post rst we", 32'(cpu_we), 32'd1);
    check("post rst wins", cpu_wins, 32'hDEAD_BEEF);
    check("post rst wcount", 32'(wcount), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
